win_scanner: RTL
================

Name: win_scanner

Overview:
- Sits directly downstream of the Ownership block. Consumes the same 6x7 `tokens` board that Colors reads.
- On a start pulse, issued after each confirmed move, it snapshots the board and scans one anchor cell per cycle for four-in-a-row in 4 directions.
- Reports winner/draw to game control and the PvE bot; latches a sticky `game_over` until a new game.

Parameters:
- ROWS, 6, board rows; row 0 is the top row, matching Colors.
- COLS, 7, board columns.
- WIN_LEN, 4, cells in a winning line.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tokens  in  2 x [ROWS][COLS]  board; 00 empty, 01 player 1, 10 player 2, 11 treated as empty.
- start  in  1  request a scan; single-cycle pulse expected, level tolerated.
- clear  in  1  synchronous new-game clear.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse: result valid.
- winner  out  2  00 none, 01 P1, 10 P2; held until next scan start or clear.
- draw  out  1  board full, no winner; held like `winner`.
- game_over  out  1  sticky: set when done with winner!=00 or draw=1.

Behaviour:
- Reset (reset=0, async): state IDLE; busy=0, done=0, winner=00, draw=0, game_over=0, anchor=0, snapshot all 00.
- States: IDLE, SCAN, DONE.
- IDLE:
  - On clock edge with start=1, clear=0, game_over=0: snapshot<=tokens, anchor<=0, state<=SCAN, winner<=00, draw<=0.
  - start while game_over=1 is ignored.
- SCAN:
  - busy=1. Anchor index k = r*COLS+c, row-major, 0..ROWS*COLS-1; one anchor evaluated per cycle from snapshot only. Changes on `tokens` during a scan have no effect.
  - Four windows per anchor: H (r,c..c+3), V (r..r+3,c), DR (r+i,c+i), DL (r+i,c-i).
  - Out-of-bounds windows never match. A window matches when all 4 cells are equal and in {01,10}.
  - On first match: winner<=that owner, state<=DONE.
  - Priority within an anchor: H > V > DR > DL. Across anchors: lowest k first.
  - If k=ROWS*COLS-1 with no match: draw<=(no snapshot cell is 00 or 11), state<=DONE.
- DONE: done=1, busy=0 for exactly one cycle. game_over<=game_over|(winner!=00)|draw. state<=IDLE.
- Latency: start edge to done high = k+2 cycles for a win at anchor k. A full scan with no win has done in cycle ROWS*COLS+1 (43 at defaults).
- start while busy or in DONE: ignored, no queuing.
- clear=1 in any state: next edge state<=IDLE, winner<=00, draw<=0, game_over<=0, done<=0. clear beats start in the same cycle. A scan is aborted mid-SCAN with no done pulse.
- Both players having a line (illegal board): first in scan order wins. No error flag.
- Reset asserted mid-scan: immediate return to reset values.

Optional Feature:
- Macro WIN_HIGHLIGHT_EN.
- When defined:
  - Extra output win_cells [ROWS*COLS-1:0]; bit r*COLS+c set for the 4 cells of the winning window.
  - Registered together with `winner`; held until next start or clear; reset/clear to 0.
  - Colors may blink those tokens.
- When undefined: port absent; no extra flops.

Decomposition:
- Shared package c4_pkg:
  - ROWS/COLS/WIN_LEN constants.
  - token_t enum: EMPTY=2'b00, P1=2'b01, P2=2'b10.
  - dir_t enum: H, V, DR, DL.
  - scan_state_t enum: IDLE, SCAN, DONE.
- These are shared with Ownership, Colors and PvE.
- One combinational sub-module, c4_window_match. Inputs: four token_t. Outputs: match and owner. Instantiated 4 times, once per direction.

Test Plan:
- Empty board, start -> done exactly 43 cycles after start edge; winner=00, draw=0, game_over=0.
- P1 at row5 cols 0..3 (k=35) -> done at cycle 37; winner=01; game_over=1. A second start produces no busy.
- P2 diagonal DL anchored (2,6): (2,6),(3,5),(4,4),(5,3) -> winner=10, done at cycle 22 (k=20). With WIN_HIGHLIGHT_EN, win_cells bits 20,26,32,38 set.
- Full board in an alternating no-line pattern -> done at 43; winner=00, draw=1, game_over=1.
- Start, then flip tokens to a P1 row0 win at cycle 3 -> winner=00, since the snapshot is used. Issue clear at cycle 10 mid-scan -> busy=0 next cycle, no done pulse, all outputs 00/0.
- Drive start and clear together; then drive reset low mid-SCAN -> no scan starts, and outputs reset immediately (async).

Source files
------------

// File: rtl/c4_pkg.sv
// c4_pkg: board geometry, token/direction/state types and scan helpers shared across the Connect-4 blocks.
package c4_pkg;
    localparam int ROWS = 6;
    localparam int COLS = 7;
    localparam int WIN_LEN = 4;
    localparam int CELLS = ROWS * COLS;
    typedef enum logic [1:0] {EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10} token_t;
    typedef enum logic [1:0] {H, V, DR, DL} dir_t;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;
    // 2'b11 is not a player, so it folds into EMPTY and can never form a line
    function automatic token_t to_token(logic [1:0] t);
        return t == 2'b01 ? P1 : t == 2'b10 ? P2 : EMPTY;
    endfunction
    function automatic int row_step(int d);
        return d == int'(H) ? 0 : 1;
    endfunction
    function automatic int col_step(int d);
        return d == int'(V) ? 0 : d == int'(DL) ? -1 : 1;
    endfunction
endpackage

// File: rtl/win_scanner_if.sv
// win_scanner_if: board input, scan request/clear and result outputs of the win scanner.
// Optional win_cells highlight mask is present only when WIN_HIGHLIGHT_EN is defined.
interface win_scanner_if;
    import c4_pkg::*;
    logic [ROWS-1:0][COLS-1:0][1:0] tokens;
    logic start;
    logic clear;
    logic busy;
    logic done;
    logic [1:0] winner;
    logic draw;
    logic game_over;
`ifdef WIN_HIGHLIGHT_EN
    logic [CELLS-1:0] win_cells;
    modport master(output tokens, start, clear, input busy, done, winner, draw, game_over, win_cells);
    modport slave(input tokens, start, clear, output busy, done, winner, draw, game_over, win_cells);
`else
    modport master(output tokens, start, clear, input busy, done, winner, draw, game_over);
    modport slave(input tokens, start, clear, output busy, done, winner, draw, game_over);
`endif
endinterface

// File: rtl/c4_window_match.sv
// c4_window_match: flags a four-cell window owned entirely by one player.
module c4_window_match
    import c4_pkg::*;
(
    input  token_t a,
    input  token_t b,
    input  token_t c,
    input  token_t d,
    output logic   match,
    output token_t owner
);
    assign match = a != EMPTY && a == b && a == c && a == d;
    assign owner = match ? a : EMPTY;
endmodule

// File: rtl/win_scanner.sv
// win_scanner: snapshots the board on start and checks one anchor cell per cycle for four-in-a-row.
// Define WIN_HIGHLIGHT_EN to add the win_cells mask of the winning window.
module win_scanner
    import c4_pkg::*;
(
    input logic         clock,
    input logic         reset,
    win_scanner_if.slave bus
);
    scan_state_t state, state_next;
    logic [ROWS-1:0][COLS-1:0][1:0] snap;
    logic [2:0] row, col;
    token_t winner;
    logic draw, game_over;
    token_t cells [4][WIN_LEN];
    token_t owner [4];
    logic [3:0] match;
    logic hit, last, full;
    dir_t hit_dir;

    function automatic token_t cell_at(int r, int c);
        return (r < 0 || r >= ROWS || c < 0 || c >= COLS) ? EMPTY : to_token(snap[r[2:0]][c[2:0]]);
    endfunction

    // Out-of-board cells read as EMPTY, so windows that leave the board never match
    always_comb begin
        for (int d = 0; d < 4; d++)
            for (int i = 0; i < WIN_LEN; i++)
                cells[d][i] = cell_at(int'(row) + i * row_step(d), int'(col) + i * col_step(d));
    end

    for (genvar g = 0; g < 4; g++) begin : g_win
        c4_window_match u_match (
            .a(cells[g][0]), .b(cells[g][1]), .c(cells[g][2]), .d(cells[g][3]),
            .match(match[g]), .owner(owner[g])
        );
    end

    assign hit = |match;
    assign hit_dir = match[0] ? H : match[1] ? V : match[2] ? DR : DL;
    assign last = row == 3'(ROWS - 1) && col == 3'(COLS - 1);

    always_comb begin
        full = 1'b1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                full = full & (to_token(snap[r][c]) != EMPTY);
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_next;

    always_comb begin
        state_next = state;
        state_next = bus.clear ? IDLE
                   : state == IDLE ? (bus.start && !game_over ? SCAN : IDLE)
                   : state == SCAN ? (hit || last ? DONE : SCAN)
                   : IDLE;
        bus.busy = state == SCAN;
        bus.done = state == DONE;
    end

`ifdef WIN_HIGHLIGHT_EN
    logic [CELLS-1:0] win_cells, mask;
    always_comb begin
        int idx;
        mask = '0;
        for (int i = 0; i < WIN_LEN; i++) begin
            idx = (int'(row) + i * row_step(int'(hit_dir))) * COLS + int'(col) + i * col_step(int'(hit_dir));
            if (hit) mask[idx[5:0]] = 1'b1;
        end
    end
    assign bus.win_cells = win_cells;
`endif

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            snap <= '0;
            row <= '0;
            col <= '0;
            winner <= EMPTY;
            draw <= 1'b0;
            game_over <= 1'b0;
`ifdef WIN_HIGHLIGHT_EN
            win_cells <= '0;
`endif
        end else if (bus.clear) begin
            winner <= EMPTY;
            draw <= 1'b0;
            game_over <= 1'b0;
`ifdef WIN_HIGHLIGHT_EN
            win_cells <= '0;
`endif
        end else if (state == IDLE && bus.start && !game_over) begin
            snap <= bus.tokens;
            row <= '0;
            col <= '0;
            winner <= EMPTY;
            draw <= 1'b0;
`ifdef WIN_HIGHLIGHT_EN
            win_cells <= '0;
`endif
        end else if (state == SCAN) begin
            if (hit) begin
                winner <= owner[hit_dir];
`ifdef WIN_HIGHLIGHT_EN
                win_cells <= mask;
`endif
            end else if (last) draw <= full;
            else begin
                col <= col == 3'(COLS - 1) ? 3'd0 : col + 3'd1;
                row <= col == 3'(COLS - 1) ? row + 3'd1 : row;
            end
        end else if (state == DONE) game_over <= game_over | (winner != EMPTY) | draw;

    assign bus.winner = winner;
    assign bus.draw = draw;
    assign bus.game_over = game_over;
endmodule
